mdio_slave: RTL and testbench

Clause-22 MDIO management responder (PHY side) for the EthCore management path. Oversamples MDC/MDIO on the system clock, decodes read and write frames addressed to its PHY address, and drives read data back through a split tri-state pad. It exposes a pulse-based register port to a local 32×16 register file. It lets an on-chip PCS/PHY model be managed by the existing MDIO master, which sends frames without preamble.

---
 rtl/mdio_slave_if.sv | 32 +++
 rtl/mdio_slave.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_mdio_slave.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : mdio_slave_if
// Purpose  : Register-port bundle between the MDIO responder and the local
//            32x16 register file. The responder initiates every access, so
//            it owns the master modport.
// Revision : 1.0 - initial release
// ============================================================================
interface mdio_slave_if;
  logic [4:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [15:0] reg_rdata;

  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_wr,
    output reg_rd,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_wr,
    input  reg_rd,
    output reg_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mdio_slave.sv
`default_nettype none
// ============================================================================
// Module   : mdio_slave
// Purpose  : Clause-22 MDIO responder (PHY side). Oversamples MDC/MDIO on
//            clk, decodes read/write frames for its PHY address, strobes a
//            local register port and drives read data on a split pad.
// Revision : 1.0 - initial release
// ============================================================================
module mdio_slave #(
  parameter int SYNC_STAGES  = 2,
  parameter int PREAMBLE_MIN = 0,
  parameter int BCAST_EN     = 0,
  parameter int TIMEOUT_CLKS = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mdc,
  input  logic       mdio_i,
  output logic       mdio_o,
  output logic       mdio_oe,
  input  logic [4:0] phy_addr,
  output logic       frame_err,
  mdio_slave_if.master regs
);

  localparam int                c_WD_W    = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CLKS - 1);
  localparam logic [5:0]        c_PRE_MIN = 6'(PREAMBLE_MIN);
  localparam logic [5:0]        c_PRE_SAT = 6'd32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ST    = 3'd1,
    S_OP    = 3'd2,
    S_PHYAD = 3'd3,
    S_REGAD = 3'd4,
    S_TA    = 3'd5,
    S_DATA  = 3'd6,
    S_SKIP  = 3'd7
  } state_t;

  // synchronizers and edge detection
  logic [SYNC_STAGES-1:0] r_mdc_sync;
  logic [SYNC_STAGES-1:0] r_mdio_sync;
  logic                   r_mdc_q;
  logic                   w_mdc_s;
  logic                   w_bit;
  logic                   w_rise;
  logic                   w_fall;

  // frame state
  state_t      r_state,   w_state_nxt;
  logic [5:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [5:0]  r_pre_cnt, w_pre_cnt_nxt;
  logic [15:0] r_sr,      w_sr_nxt;
  logic        r_rd_op,   w_rd_op_nxt;
  logic        r_rd_p1;
  logic [c_WD_W-1:0] r_wd;
  logic        w_timeout;
  logic        w_end;

  // registered outputs
  logic        r_mdio_o,    w_o_nxt;
  logic        r_mdio_oe,   w_oe_nxt;
  logic [4:0]  r_reg_addr,  w_addr_nxt;
  logic [15:0] r_reg_wdata, w_wdata_nxt;
  logic        r_reg_wr,    w_wr_nxt;
  logic        r_reg_rd,    w_rd_nxt;
  logic        r_frame_err, w_err_nxt;

  // address decode on the bit that completes REGAD
  logic [4:0]  w_phyad;
  logic [4:0]  w_regad;
  logic        w_match;

  assign w_mdc_s = r_mdc_sync[SYNC_STAGES-1];
  assign w_bit   = r_mdio_sync[SYNC_STAGES-1];
  assign w_rise  = w_mdc_s & ~r_mdc_q;
  assign w_fall  = ~w_mdc_s & r_mdc_q;

  assign w_phyad = r_sr[8:4];
  assign w_regad = {r_sr[3:0], w_bit};
  assign w_match = (w_phyad == phy_addr) ||
                   ((BCAST_EN != 0) && (w_phyad == 5'd0) && !r_rd_op);

  assign w_timeout = (r_state != S_IDLE) && !w_rise && !w_fall && (r_wd == c_WD_LAST);

  // Bring mdc/mdio into the clk domain; idle MDIO is pulled high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mdc_sync  <= '0;
      r_mdio_sync <= '1;
      r_mdc_q     <= 1'b0;
    end else begin
      r_mdc_sync  <= {r_mdc_sync[SYNC_STAGES-2:0], mdc};
      r_mdio_sync <= {r_mdio_sync[SYNC_STAGES-2:0], mdio_i};
      r_mdc_q     <= w_mdc_s;
    end
  end

  // Watchdog: runs only inside a frame, cleared by any MDC edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd <= '0;
    end else if ((r_state == S_IDLE) || w_rise || w_fall || w_timeout) begin
      r_wd <= '0;
    end else begin
      r_wd <= r_wd + 1'b1;
    end
  end

  // Next-state and output decode; inputs act on rising MDC, pad on falling MDC
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_pre_cnt_nxt = r_pre_cnt;
    w_sr_nxt      = r_sr;
    w_rd_op_nxt   = r_rd_op;
    w_oe_nxt      = r_mdio_oe;
    w_o_nxt       = r_mdio_o;
    w_addr_nxt    = r_reg_addr;
    w_wdata_nxt   = r_reg_wdata;
    w_wr_nxt      = 1'b0;
    w_rd_nxt      = 1'b0;
    w_err_nxt     = 1'b0;
    w_end         = 1'b0;

    // Read data arrives two clk after the strobe, well before the TA drive
    if (r_rd_p1) begin
      w_sr_nxt = regs.reg_rdata;
    end

    if (w_timeout) begin
      w_oe_nxt  = 1'b0;
      w_o_nxt   = 1'b0;
      w_err_nxt = 1'b1;
      w_end     = 1'b1;
    end else if (w_rise) begin
      case (r_state)
        S_IDLE: begin
          if (w_bit) begin
            if (r_pre_cnt != c_PRE_SAT) w_pre_cnt_nxt = r_pre_cnt + 6'd1;
          end else if (r_pre_cnt >= c_PRE_MIN) begin
            w_state_nxt   = S_ST;
            w_pre_cnt_nxt = '0;
          end else begin
            w_pre_cnt_nxt = '0;
          end
        end
        S_ST: begin
          if (w_bit) begin
            w_state_nxt   = S_OP;
            w_bit_cnt_nxt = '0;
          end else begin
            w_err_nxt = 1'b1;
            w_end     = 1'b1;
          end
        end
        S_OP: begin
          w_sr_nxt = {r_sr[14:0], w_bit};
          if (r_bit_cnt == 6'd0) begin
            w_bit_cnt_nxt = 6'd1;
          end else if ({r_sr[0], w_bit} == 2'b10) begin
            w_rd_op_nxt   = 1'b1;
            w_state_nxt   = S_PHYAD;
            w_bit_cnt_nxt = '0;
          end else if ({r_sr[0], w_bit} == 2'b01) begin
            w_rd_op_nxt   = 1'b0;
            w_state_nxt   = S_PHYAD;
            w_bit_cnt_nxt = '0;
          end else begin
            w_err_nxt = 1'b1;
            w_end     = 1'b1;
          end
        end
        S_PHYAD: begin
          w_sr_nxt = {r_sr[14:0], w_bit};
          if (r_bit_cnt == 6'd4) begin
            w_state_nxt   = S_REGAD;
            w_bit_cnt_nxt = '0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 6'd1;
          end
        end
        S_REGAD: begin
          w_sr_nxt = {r_sr[14:0], w_bit};
          if (r_bit_cnt == 6'd4) begin
            w_bit_cnt_nxt = '0;
            if (w_match) begin
              w_addr_nxt  = w_regad;
              w_rd_nxt    = r_rd_op;
              w_state_nxt = S_TA;
            end else begin
              w_state_nxt = S_SKIP;
            end
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 6'd1;
          end
        end
        S_TA: begin
          // the first TA bit is don't-care; the second must be 0 on a write
          if (!r_rd_op) begin
            if (r_bit_cnt == 6'd0) begin
              w_bit_cnt_nxt = 6'd1;
            end else if (w_bit) begin
              w_err_nxt = 1'b1;
              w_end     = 1'b1;
            end else begin
              w_state_nxt   = S_DATA;
              w_bit_cnt_nxt = '0;
            end
          end
        end
        S_DATA: begin
          if (!r_rd_op) begin
            w_sr_nxt = {r_sr[14:0], w_bit};
            if (r_bit_cnt == 6'd15) begin
              w_wdata_nxt = {r_sr[14:0], w_bit};
              w_wr_nxt    = 1'b1;
              w_end       = 1'b1;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + 6'd1;
            end
          end
        end
        S_SKIP: begin
          // TA plus 16 data bits of a frame for another PHY
          if (r_bit_cnt == 6'd17) begin
            w_end = 1'b1;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 6'd1;
          end
        end
        default: begin
          w_end = 1'b1;
        end
      endcase
    end else if (w_fall && r_rd_op) begin
      if (r_state == S_TA) begin
        if (r_bit_cnt == 6'd0) begin
          w_bit_cnt_nxt = 6'd1;
        end else begin
          w_oe_nxt      = 1'b1;
          w_o_nxt       = 1'b0;
          w_state_nxt   = S_DATA;
          w_bit_cnt_nxt = '0;
        end
      end else if (r_state == S_DATA) begin
        if (r_bit_cnt == 6'd16) begin
          w_oe_nxt = 1'b0;
          w_o_nxt  = 1'b0;
          w_end    = 1'b1;
        end else begin
          w_o_nxt       = r_sr[15];
          w_sr_nxt      = {r_sr[14:0], 1'b0};
          w_bit_cnt_nxt = r_bit_cnt + 6'd1;
        end
      end
    end

    if (w_end) begin
      w_state_nxt   = S_IDLE;
      w_bit_cnt_nxt = '0;
      w_pre_cnt_nxt = '0;
    end
  end

  // Frame state and registered outputs; reset releases the pad at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_pre_cnt   <= '0;
      r_sr        <= '0;
      r_rd_op     <= 1'b0;
      r_rd_p1     <= 1'b0;
      r_mdio_o    <= 1'b0;
      r_mdio_oe   <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_reg_wr    <= 1'b0;
      r_reg_rd    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_pre_cnt   <= w_pre_cnt_nxt;
      r_sr        <= w_sr_nxt;
      r_rd_op     <= w_rd_op_nxt;
      r_rd_p1     <= r_reg_rd;
      r_mdio_o    <= w_o_nxt;
      r_mdio_oe   <= w_oe_nxt;
      r_reg_addr  <= w_addr_nxt;
      r_reg_wdata <= w_wdata_nxt;
      r_reg_wr    <= w_wr_nxt;
      r_reg_rd    <= w_rd_nxt;
      r_frame_err <= w_err_nxt;
    end
  end

  assign mdio_o         = r_mdio_o;
  assign mdio_oe        = r_mdio_oe;
  assign frame_err      = r_frame_err;
  assign regs.reg_addr  = r_reg_addr;
  assign regs.reg_wdata = r_reg_wdata;
  assign regs.reg_wr    = r_reg_wr;
  assign regs.reg_rd    = r_reg_rd;

endmodule
`default_nettype wire

// File: tb/tb_mdio_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdio_slave
// Purpose  : Scoreboard bench for mdio_slave. Three instances (default,
//            broadcast-enabled, 32-bit preamble) share one MDIO master whose
//            MDC is steered to the instance under test.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdio_slave;

  localparam int HALF     = 12;
  localparam int K_WR     = 0;
  localparam int K_RD     = 1;
  localparam int K_ERR    = 2;
  localparam int K_RDATA  = 3;
  localparam int K_RABORT = 4;

  typedef struct {
    int kind;
    int dut;
    int addr;
    int data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mdc_m;
  logic       mdio_m;
  int         sel;
  logic [4:0] phy_addr = 5'd5;

  logic [2:0] mdc_d;
  logic [2:0] pad;
  logic [2:0] oe;
  logic [2:0] o;
  logic [2:0] ferr;
  logic [2:0] wr_s;
  logic [2:0] rd_s;
  logic [4:0] addr_s [3];
  logic [15:0] wdata_s [3];

  ev_t exp_q[$];
  int  n_pass  = 0;
  int  n_total = 0;

  mdio_slave_if bus0 ();
  mdio_slave_if bus1 ();
  mdio_slave_if bus2 ();

  always #5 clk = ~clk;

  // register-file model: register 2 holds 0x1234, others 0xC0nn
  function automatic logic [15:0] rf(input logic [4:0] a);
    return (a == 5'd2) ? 16'h1234 : {11'h600, a};
  endfunction

  assign bus0.reg_rdata = rf(bus0.reg_addr);
  assign bus1.reg_rdata = rf(bus1.reg_addr);
  assign bus2.reg_rdata = rf(bus2.reg_addr);

  assign mdc_d[0] = (sel == 0) && mdc_m;
  assign mdc_d[1] = (sel == 1) && mdc_m;
  assign mdc_d[2] = (sel == 2) && mdc_m;
  assign pad[0]   = oe[0] ? o[0] : ((sel == 0) ? mdio_m : 1'b1);
  assign pad[1]   = oe[1] ? o[1] : ((sel == 1) ? mdio_m : 1'b1);
  assign pad[2]   = oe[2] ? o[2] : ((sel == 2) ? mdio_m : 1'b1);

  assign wr_s = {bus2.reg_wr, bus1.reg_wr, bus0.reg_wr};
  assign rd_s = {bus2.reg_rd, bus1.reg_rd, bus0.reg_rd};
  assign addr_s[0]  = bus0.reg_addr;
  assign addr_s[1]  = bus1.reg_addr;
  assign addr_s[2]  = bus2.reg_addr;
  assign wdata_s[0] = bus0.reg_wdata;
  assign wdata_s[1] = bus1.reg_wdata;
  assign wdata_s[2] = bus2.reg_wdata;

  mdio_slave #(.SYNC_STAGES(2), .PREAMBLE_MIN(0), .BCAST_EN(0), .TIMEOUT_CLKS(1024)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .mdc(mdc_d[0]), .mdio_i(pad[0]), .mdio_o(o[0]),
    .mdio_oe(oe[0]), .phy_addr(phy_addr), .frame_err(ferr[0]), .regs(bus0.master));

  mdio_slave #(.SYNC_STAGES(2), .PREAMBLE_MIN(0), .BCAST_EN(1), .TIMEOUT_CLKS(1024)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mdc(mdc_d[1]), .mdio_i(pad[1]), .mdio_o(o[1]),
    .mdio_oe(oe[1]), .phy_addr(phy_addr), .frame_err(ferr[1]), .regs(bus1.master));

  mdio_slave #(.SYNC_STAGES(2), .PREAMBLE_MIN(32), .BCAST_EN(0), .TIMEOUT_CLKS(1024)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .mdc(mdc_d[2]), .mdio_i(pad[2]), .mdio_o(o[2]),
    .mdio_oe(oe[2]), .phy_addr(phy_addr), .frame_err(ferr[2]), .regs(bus2.master));

  task automatic check_val(input string nm, input int got, input int req);
    n_total++;
    if (got == req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, got, req);
  endtask

  task automatic expect_ev(input int kind, input int dut, input int addr, input int data);
    ev_t e;
    e.kind = kind; e.dut = dut; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic got_ev(input int kind, input int dut, input int addr, input int data);
    ev_t e;
    bit  ok;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got kind=%0d dut=%0d addr=%0d data=%0h, required none",
               kind, dut, addr, data);
    end else begin
      e  = exp_q.pop_front();
      ok = (e.kind == kind) && (e.dut == dut);
      if ((kind == K_WR) || (kind == K_RD)) ok = ok && (e.addr == addr);
      if ((kind == K_WR) || (kind == K_RDATA)) ok = ok && (e.data == data);
      if (ok) n_pass++;
      else $display("FAIL event: got kind=%0d dut=%0d addr=%0d data=%0h, required kind=%0d dut=%0d addr=%0d data=%0h",
                    kind, dut, addr, data, e.kind, e.dut, e.addr, e.data);
    end
  endtask

  // Monitor: turns strobes and pad activity into events for the scoreboard
  logic [2:0]  prev_oe  = '0;
  logic [2:0]  prev_mdc = '0;
  logic [2:0]  coll     = '0;
  int          cnt [3];
  logic [16:0] sh  [3];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (mdc_d[k] && !prev_mdc[k] && coll[k]) begin
        sh[k]  = {sh[k][15:0], pad[k]};
        cnt[k] = cnt[k] + 1;
      end
      if (oe[k] && !prev_oe[k]) begin
        coll[k] = 1'b1;
        cnt[k]  = 0;
        sh[k]   = '0;
      end
      if (!oe[k] && prev_oe[k]) begin
        got_ev((cnt[k] == 17) ? K_RDATA : K_RABORT, k, 0, int'(sh[k]));
        coll[k] = 1'b0;
      end
      if (wr_s[k]) got_ev(K_WR, k, int'(addr_s[k]), int'(wdata_s[k]));
      if (rd_s[k]) got_ev(K_RD, k, int'(addr_s[k]), 0);
      if (ferr[k]) got_ev(K_ERR, k, 0, 0);
      prev_oe[k]  = oe[k];
      prev_mdc[k] = mdc_d[k];
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mbit(input logic b);
    mdio_m = b;
    wclk(HALF);
    mdc_m = 1'b1;
    wclk(HALF);
    mdc_m = 1'b0;
  endtask

  task automatic send(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) mbit(v[i]);
  endtask

  task automatic ones(input int n);
    for (int i = 0; i < n; i++) mbit(1'b1);
  endtask

  task automatic wr_frame(input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] d);
    send({2'b01, 2'b01, pa, ra, 2'b10, d}, 32);
  endtask

  task automatic rd_hdr(input logic [4:0] pa, input logic [4:0] ra);
    send({18'd0, 2'b01, 2'b10, pa, ra}, 14);
  endtask

  initial begin
    sel    = 0;
    mdc_m  = 1'b0;
    mdio_m = 1'b1;
    rst_n  = 1'b0;
    wclk(5);
    rst_n  = 1'b1;
    wclk(5);

    check_val("rst_oe",     int'(oe), 0);
    check_val("rst_o",      int'(o), 0);
    check_val("rst_ferr",   int'(ferr), 0);
    check_val("rst_addr",   int'(bus0.reg_addr), 0);
    check_val("rst_wdata",  int'(bus0.reg_wdata), 0);
    check_val("rst_wr",     int'(wr_s), 0);
    check_val("rst_rd",     int'(rd_s), 0);

    // write 0xBEEF to reg 3, no preamble
    expect_ev(K_WR, 0, 3, 32'hBEEF);
    wr_frame(5'd5, 5'd3, 16'hBEEF);
    ones(4);

    // read reg 2: TA zero then 0x1234 MSB first
    expect_ev(K_RD, 0, 2, 0);
    expect_ev(K_RDATA, 0, 0, 32'h0000_1234);
    rd_hdr(5'd5, 5'd2);
    ones(18);
    ones(4);

    // read to another PHY is skipped; following write is accepted
    rd_hdr(5'd7, 5'd2);
    ones(18);
    expect_ev(K_WR, 0, 12, 32'hA5C3);
    wr_frame(5'd5, 5'd12, 16'hA5C3);
    ones(4);

    // OP=11 is malformed
    expect_ev(K_ERR, 0, 0, 0);
    send(32'h7, 4);
    ones(4);

    // broadcast instance: PHYAD 0 write accepted, read ignored
    sel = 1;
    expect_ev(K_WR, 1, 9, 32'h5A5A);
    wr_frame(5'd0, 5'd9, 16'h5A5A);
    ones(4);
    rd_hdr(5'd0, 5'd2);
    ones(18);
    ones(4);

    // preamble instance: 31 ones rejected, 32 ones accepted
    sel = 2;
    ones(31);
    wr_frame(5'd5, 5'd7, 16'h1357);
    ones(4);
    ones(32);
    expect_ev(K_WR, 2, 7, 32'h2468);
    wr_frame(5'd5, 5'd7, 16'h2468);
    ones(4);

    // MDC stalls mid read data: watchdog aborts
    sel = 0;
    expect_ev(K_RD, 0, 4, 0);
    expect_ev(K_RABORT, 0, 0, 0);
    expect_ev(K_ERR, 0, 0, 0);
    rd_hdr(5'd5, 5'd4);
    ones(7);
    mdio_m = 1'b1;
    wclk(1100);
    check_val("timeout_oe", int'(oe[0]), 0);
    ones(4);

    // reset mid read drops the pad enable immediately
    expect_ev(K_RD, 0, 2, 0);
    expect_ev(K_RABORT, 0, 0, 0);
    rd_hdr(5'd5, 5'd2);
    ones(5);
    wclk(6);
    check_val("pre_rst_oe", int'(oe[0]), 1);
    rst_n = 1'b0;
    #1;
    check_val("rst_async_oe", int'(oe[0]), 0);
    wclk(3);
    rst_n = 1'b1;
    wclk(3);
    ones(4);

    // responder is usable again after the reset
    expect_ev(K_WR, 0, 1, 32'h0001);
    wr_frame(5'd5, 5'd1, 16'h0001);
    ones(4);

    wclk(20);
    check_val("queue_empty", exp_q.size(), 0);
    check_val("end_oe", int'(oe), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
